debounce_bank: RTL

Parametrised N-channel input conditioner for the pet front panel: synchronises, debounces and shapes push-button and sensor (ultrasonic, photocell) inputs for the mode/state machine. Each channel has its own runtime mode: level, toggle, press pulse or long-press pulse. It adds toggle clear and long-press detection, and drives both a mode-selected output and raw per-channel event flags.

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 110 +++++++++++
 rtl/debounce_bank.sv | 40 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the front-panel input conditioner: channel modes,
// board/simulation timing defaults and a sizing helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_PRESS  = 2'b10,
    MODE_LONG   = 2'b11
  } mode_e;

  localparam int DB_CYCLES_BOARD   = 50000;
  localparam int LONG_CYCLES_BOARD = 250000000;
  localparam int DB_CYCLES_SIM     = 5;
  localparam int LONG_CYCLES_SIM   = 20;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchroniser, debounce counter, press/toggle
// edge shaping, long-press detector and the per-mode output select.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_BOARD,
  parameter int LONG_CYCLES = LONG_CYCLES_BOARD
) (
  input  logic       clk_i,
  input  logic       reset_tmp_i,
  input  logic       raw_i,
  input  logic [1:0] mode_i,
  input  logic       toggle_clr_i,
  output logic       level_o,
  output logic       press_o,
  output logic       long_press_o,
  output logic       toggle_o,
  output logic       out_o
);

  localparam int CNT_W = $clog2(max_int(DB_CYCLES, LONG_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             long_q, long_d;
  logic             toggle_q, toggle_d;
  logic             fired_q, fired_d;
  logic             differ_s, flip_s, rise_s;

  always_ff @(posedge clk_i or posedge reset_tmp_i) begin
    if (reset_tmp_i) begin
      sync_q     <= 2'b00;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      long_q     <= 1'b0;
      toggle_q   <= 1'b0;
      fired_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], raw_i};
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      long_q     <= long_d;
      toggle_q   <= toggle_d;
      fired_q    <= fired_d;
    end
  end

  // A bounce back to the current level discards all accumulated stability.
  always_comb begin
    differ_s   = sync_q[1] ^ level_q;
    flip_s     = differ_s && (db_cnt_q == DB_LAST);
    rise_s     = flip_s && !level_q;
    db_cnt_d   = '0;
    hold_cnt_d = '0;
    fired_d    = 1'b0;
    long_d     = 1'b0;
    if (differ_s && !flip_s) begin
      db_cnt_d = db_cnt_q + CNT_ONE;
    end else begin
      db_cnt_d = '0;
    end
    level_d = level_q ^ flip_s;
    press_d = rise_s;
    if (toggle_clr_i) begin
      toggle_d = 1'b0;
    end else begin
      toggle_d = toggle_q ^ rise_s;
    end
    // hold_cnt saturates; fired_q blocks a repeat pulse until the next rise
    if (level_q) begin
      long_d = (hold_cnt_q == LONG_LAST) && !fired_q;
      if (hold_cnt_q == LONG_LAST) begin
        hold_cnt_d = hold_cnt_q;
      end else begin
        hold_cnt_d = hold_cnt_q + CNT_ONE;
      end
      fired_d = fired_q || long_d;
    end else begin
      long_d     = 1'b0;
      hold_cnt_d = '0;
      fired_d    = 1'b0;
    end
  end

  always_comb begin
    case (mode_e'(mode_i))
      MODE_LEVEL:  out_o = level_q;
      MODE_TOGGLE: out_o = toggle_q;
      MODE_PRESS:  out_o = press_q;
      MODE_LONG:   out_o = long_q;
      default:     out_o = level_q;
    endcase
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign long_press_o = long_q;
  assign toggle_o     = toggle_q;

endmodule

// File: rtl/debounce_bank.sv
// N independent debounce channels for the pet front panel buttons and sensors;
// each channel's out bit follows the function chosen by its 2-bit mode field.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH        = 6,
  parameter int DB_CYCLES   = DB_CYCLES_BOARD,
  parameter int LONG_CYCLES = LONG_CYCLES_BOARD
) (
  input  logic              clk,
  input  logic              reset_tmp,
  input  logic [N_CH-1:0]   raw_in,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   toggle_clr,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   press,
  output logic [N_CH-1:0]   long_press,
  output logic [N_CH-1:0]   toggle,
  output logic [N_CH-1:0]   out
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_ch (
      .clk_i        (clk),
      .reset_tmp_i  (reset_tmp),
      .raw_i        (raw_in[g]),
      .mode_i       (mode[2*g+1:2*g]),
      .toggle_clr_i (toggle_clr[g]),
      .level_o      (level[g]),
      .press_o      (press[g]),
      .long_press_o (long_press[g]),
      .toggle_o     (toggle[g]),
      .out_o        (out[g])
    );
  end

endmodule
